// File: rtl/agc_pkg.sv
// Shared types and helpers for the AGC gain-decision stage.
//   agc_state_e : decision FSM states (StHold is only reachable when the
//                 AGC_HOLDOFF_EN build option is defined).
//   sat_sub     : subtract with floor at zero.
//   sat_add     : add with ceiling at a given maximum.
//   clamp_hi    : upper dead-band edge, clamped to the sample range.
//   clamp_lo    : lower dead-band edge, clamped at zero.
package agc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StEval,
    StSend,
    StHold
  } agc_state_e;

  function automatic int unsigned sat_sub(int unsigned val, int unsigned step);
    return (val > step) ? val - step : 0;
  endfunction

  function automatic int unsigned sat_add(int unsigned val, int unsigned step,
                                          int unsigned max_val);
    return (val + step < max_val) ? val + step : max_val;
  endfunction

  function automatic int unsigned clamp_hi(int unsigned target, int unsigned hyst,
                                           int unsigned width);
    int unsigned top;
    top = (1 << width) - 1;
    return (target + hyst > top) ? top : target + hyst;
  endfunction

  function automatic int unsigned clamp_lo(int unsigned target, int unsigned hyst);
    return (target > hyst) ? target - hyst : 0;
  endfunction

endpackage

// File: rtl/agc_holdoff_timer.sv
// Settle timer for the AGC decision stage. A start pulse loads the counter
// with HOLDOFF; done_o pulses in the last counted cycle so the caller leaves
// its wait state after exactly HOLDOFF cycles.
//   clk_i   : system clock
//   reset_i : synchronous, active-high reset
//   start_i : begin a new hold-off period
//   done_o  : one-cycle pulse in the final hold-off cycle
module agc_holdoff_timer #(
  parameter int unsigned HOLDOFF = 256
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  output logic done_o
);

  // A zero hold-off still needs one cycle in the wait state.
  localparam int unsigned Cycles = (HOLDOFF == 0) ? 1 : HOLDOFF;
  localparam int unsigned CntW   = $clog2(Cycles + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= CntW'(Cycles);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign done_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/agc_gain_ctrl.sv
// AGC gain-decision stage. Each accepted RMS sample is compared with a
// hysteresis window around TARGET; the PGA gain code is stepped down when too
// loud and up when too quiet, saturating at 0 and 2^GAIN_BITS-1. New codes are
// offered on a valid/ready stream and applied on handshake.
// Build option: AGC_HOLDOFF_EN adds a HOLDOFF-cycle settle period after each
// accepted gain change (samples arriving then are dropped).
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   rms_TVALID, rms_TDATA   : RMS sample stream (no back-pressure)
//   gain_TVALID/TDATA/TREADY: outgoing gain-code stream
//   gain_code               : currently applied gain
//   at_min, at_max          : gain_code at floor / ceiling
//   drop_pulse              : sample arrived while busy and was discarded
module agc_gain_ctrl
  import agc_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned GAIN_BITS   = 4,
  parameter int unsigned GAIN_RESET  = 8,
  parameter int unsigned TARGET      = 64,
  parameter int unsigned HYST        = 8,
  parameter int unsigned ATTACK_STEP = 2,
  parameter int unsigned DECAY_STEP  = 1,
  parameter int unsigned HOLDOFF     = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rms_TVALID,
  input  logic [WIDTH-1:0]     rms_TDATA,
  output logic                 gain_TVALID,
  output logic [GAIN_BITS-1:0] gain_TDATA,
  input  logic                 gain_TREADY,
  output logic [GAIN_BITS-1:0] gain_code,
  output logic                 at_min,
  output logic                 at_max,
  output logic                 drop_pulse
);

  localparam int unsigned   GainMax  = (1 << GAIN_BITS) - 1;
  // Thresholds carry one extra bit so TARGET+HYST cannot wrap.
  localparam logic [WIDTH:0] ThreshHi = (WIDTH + 1)'(clamp_hi(TARGET, HYST, WIDTH));
  localparam logic [WIDTH:0] ThreshLo = (WIDTH + 1)'(clamp_lo(TARGET, HYST));

  agc_state_e           state_q;
  logic [WIDTH-1:0]     sample_q;
  logic [GAIN_BITS-1:0] gain_code_q;
  logic [GAIN_BITS-1:0] gain_tdata_q;
  logic                 gain_tvalid_q;
  logic [GAIN_BITS-1:0] gain_next;
  logic                 handshake;

  always_comb begin
    gain_next = gain_code_q;
    if ({1'b0, sample_q} > ThreshHi) begin
      gain_next = GAIN_BITS'(sat_sub(32'(gain_code_q), ATTACK_STEP));
    end else if ({1'b0, sample_q} < ThreshLo) begin
      gain_next = GAIN_BITS'(sat_add(32'(gain_code_q), DECAY_STEP, GainMax));
    end
  end

  assign handshake = (state_q == StSend) && gain_TREADY;

`ifdef AGC_HOLDOFF_EN
  logic hold_done;

  agc_holdoff_timer #(
    .HOLDOFF (HOLDOFF)
  ) u_holdoff_timer (
    .clk_i   (clk),
    .reset_i (reset),
    .start_i (handshake),
    .done_o  (hold_done)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      sample_q      <= '0;
      gain_code_q   <= GAIN_BITS'(GAIN_RESET);
      gain_tdata_q  <= GAIN_BITS'(GAIN_RESET);
      gain_tvalid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rms_TVALID) begin
            sample_q <= rms_TDATA;
            state_q  <= StEval;
          end
        end
        StEval: begin
          // In-band samples and saturated steps both leave gain_next unchanged.
          if (gain_next != gain_code_q) begin
            gain_tdata_q  <= gain_next;
            gain_tvalid_q <= 1'b1;
            state_q       <= StSend;
          end else begin
            state_q <= StIdle;
          end
        end
        StSend: begin
          if (handshake) begin
            gain_code_q   <= gain_tdata_q;
            gain_tvalid_q <= 1'b0;
`ifdef AGC_HOLDOFF_EN
            state_q       <= StHold;
`else
            state_q       <= StIdle;
`endif
          end
        end
`ifdef AGC_HOLDOFF_EN
        StHold: begin
          if (hold_done) begin
            state_q <= StIdle;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gain_TVALID = gain_tvalid_q;
  assign gain_TDATA  = gain_tdata_q;
  assign gain_code   = gain_code_q;
  assign at_min      = (gain_code_q == '0);
  assign at_max      = (gain_code_q == GAIN_BITS'(GainMax));
  assign drop_pulse  = rms_TVALID && (state_q != StIdle);

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// Scoreboard bench for agc_gain_ctrl: the driver runs a transaction-level
// reference model and queues per-cycle expectations plus expected gain
// transactions; a monitor on the falling edge pops and compares them.
module tb_agc_gain_ctrl;

  localparam int WIDTH       = 8;
  localparam int GAIN_BITS   = 4;
  localparam int GAIN_RESET  = 8;
  localparam int TARGET      = 64;
  localparam int HYST        = 8;
  localparam int ATTACK_STEP = 2;
  localparam int DECAY_STEP  = 1;
  localparam int HOLDOFF     = 16;
  localparam int GMAX        = (1 << GAIN_BITS) - 1;
`ifdef AGC_HOLDOFF_EN
  localparam int HOLD_CYC = HOLDOFF;
`else
  localparam int HOLD_CYC = 0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 rms_TVALID = 1'b0;
  logic [WIDTH-1:0]     rms_TDATA = '0;
  logic                 gain_TREADY = 1'b0;
  logic                 gain_TVALID;
  logic [GAIN_BITS-1:0] gain_TDATA;
  logic [GAIN_BITS-1:0] gain_code;
  logic                 at_min;
  logic                 at_max;
  logic                 drop_pulse;

  agc_gain_ctrl #(
    .WIDTH       (WIDTH),
    .GAIN_BITS   (GAIN_BITS),
    .GAIN_RESET  (GAIN_RESET),
    .TARGET      (TARGET),
    .HYST        (HYST),
    .ATTACK_STEP (ATTACK_STEP),
    .DECAY_STEP  (DECAY_STEP),
    .HOLDOFF     (HOLDOFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rms_TVALID  (rms_TVALID),
    .rms_TDATA   (rms_TDATA),
    .gain_TVALID (gain_TVALID),
    .gain_TDATA  (gain_TDATA),
    .gain_TREADY (gain_TREADY),
    .gain_code   (gain_code),
    .at_min      (at_min),
    .at_max      (at_max),
    .drop_pulse  (drop_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit check;
    int cyc;
    bit drop;
    bit valid;
    int gain;
  } rec_t;

  typedef struct {
    int code;
    int cyc;
  } txn_t;

  rec_t rec_q[$];
  txn_t txn_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model state: applied gain, pending offer, earliest accept cycle.
  int m_cyc = 0;
  int m_gain = GAIN_RESET;
  bit m_pend = 1'b0;
  int m_pend_code = 0;
  int m_offer_at = 0;
  int m_accept_at = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decision rule straight from the target window with hysteresis.
  task automatic decide(input int d);
    int hi, lo, nxt;
    hi  = (TARGET + HYST > 255) ? 255 : TARGET + HYST;
    lo  = (TARGET - HYST < 0) ? 0 : TARGET - HYST;
    nxt = m_gain;
    if (d > hi) nxt = (m_gain - ATTACK_STEP < 0) ? 0 : m_gain - ATTACK_STEP;
    else if (d < lo) nxt = (m_gain + DECAY_STEP > GMAX) ? GMAX : m_gain + DECAY_STEP;
    if (nxt != m_gain) begin
      txn_t t;
      m_pend      = 1'b1;
      m_pend_code = nxt;
      m_offer_at  = m_cyc + 2;
      t.code      = nxt;
      t.cyc       = m_cyc + 2;
      txn_q.push_back(t);
    end else begin
      m_accept_at = m_cyc + 2;
    end
  endtask

  task automatic step(input bit rst, input bit v, input int d, input bit rdy);
    rec_t r;
    bit   accept, valid_now;
    @(posedge clk);
    #1;
    reset       = rst;
    rms_TVALID  = v;
    rms_TDATA   = 8'(d);
    gain_TREADY = rdy;
    valid_now = m_pend && (m_cyc >= m_offer_at);
    accept    = v && !m_pend && (m_cyc >= m_accept_at);
    r.check = !rst;
    r.cyc   = m_cyc;
    r.drop  = v && !accept;
    r.valid = valid_now;
    r.gain  = m_gain;
    rec_q.push_back(r);
    if (rst) begin
      // An offer not yet visible is lost to the reset.
      if (m_pend && m_offer_at > m_cyc) void'(txn_q.pop_back());
      m_gain      = GAIN_RESET;
      m_pend      = 1'b0;
      m_accept_at = m_cyc + 1;
    end else begin
      if (valid_now && rdy) begin
        m_gain      = m_pend_code;
        m_pend      = 1'b0;
        m_accept_at = m_cyc + 1 + HOLD_CYC;
      end
      if (accept) decide(d);
    end
    m_cyc++;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, rdy);
  endtask

  // Monitor: one expectation record per cycle, one transaction per new offer.
  initial begin
    rec_t             r;
    txn_t             t;
    bit               pv;
    bit               pr;
    logic [GAIN_BITS-1:0] pd;
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (rec_q.size() > 0) begin
        r = rec_q.pop_front();
        if (r.check) begin
          chk("drop_pulse", drop_pulse, r.drop);
          chk("gain_TVALID", gain_TVALID, r.valid);
          chk("gain_code", gain_code, r.gain);
          chk("at_min", at_min, r.gain == 0);
          chk("at_max", at_max, r.gain == GMAX);
          if (gain_TVALID === 1'b1 && pv && !pr) chk("tdata_stable", gain_TDATA, pd);
        end
        if (gain_TVALID === 1'b1 && !pv) begin
          if (txn_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_txn: code %0d offered at cycle %0d, none expected",
                     gain_TDATA, r.cyc);
          end else begin
            t = txn_q.pop_front();
            chk("txn_code", gain_TDATA, t.code);
            chk("txn_cycle", r.cyc, t.cyc);
          end
        end
        pv = (gain_TVALID === 1'b1);
        pr = gain_TREADY;
        pd = gain_TDATA;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1);
    chk("reset_gain_code", gain_code, 8);
    chk("reset_tvalid", gain_TVALID, 0);
    chk("reset_tdata", gain_TDATA, 8);

    // Loud sample from reset gain.
    step(1'b0, 1'b1, 100, 1'b1);
    idle(3, 1'b1);
    chk("loud_gain", gain_code, 6);
    idle(HOLD_CYC, 1'b1);

    // Quiet sample, then the band edges and centre.
    step(1'b1, 1'b0, 0, 1'b1);
    step(1'b0, 1'b1, 40, 1'b1);
    idle(3 + HOLD_CYC, 1'b1);
    chk("quiet_gain", gain_code, 9);
    step(1'b0, 1'b1, 56, 1'b1);
    idle(3, 1'b1);
    step(1'b0, 1'b1, 64, 1'b1);
    idle(3, 1'b1);
    step(1'b0, 1'b1, 72, 1'b1);
    idle(3, 1'b1);
    chk("inband_gain", gain_code, 9);

    // Saturate low, then high, with a sample every cycle.
    for (int i = 0; i < 150; i++) step(1'b0, 1'b1, 255, 1'b1);
    chk("floor_gain", gain_code, 0);
    chk("floor_at_min", at_min, 1);
    for (int i = 0; i < 400; i++) step(1'b0, 1'b1, 0, 1'b1);
    chk("ceiling_gain", gain_code, 15);
    chk("ceiling_at_max", at_max, 1);
    idle(3 + HOLD_CYC, 1'b1);

    // Stalled PGA interface with samples arriving during the stall.
    step(1'b0, 1'b1, 100, 1'b0);
    idle(1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 20, 1'b0);
    chk("stall_gain", gain_code, 15);
    step(1'b0, 1'b0, 0, 1'b1);
    idle(3 + HOLD_CYC, 1'b1);
    chk("after_stall_gain", gain_code, 13);

    // Reset while an offer is pending.
    step(1'b0, 1'b1, 200, 1'b0);
    idle(3, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    chk("midsend_reset_tvalid", gain_TVALID, 0);
    chk("midsend_reset_gain", gain_code, 8);

    // Randomized traffic, biased toward the band edges.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0: d = 55;
          1: d = 56;
          2: d = 57;
          3: d = 71;
          4: d = 72;
          default: d = 73;
        endcase
      end else begin
        d = int'($urandom_range(0, 255));
      end
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, d,
           $urandom_range(0, 9) < 7);
    end

    idle(3 + HOLD_CYC, 1'b1);
    @(negedge clk);
    #1;
    chk("txn_queue_empty", txn_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/agc_gain_ctrl.md
# agc_gain_ctrl

Automatic-gain-control decision stage, directly downstream of the RMS estimator in the AGC component. Consumes each RMS sample, compares it against a target window with hysteresis, and steps a saturating programmable-gain-amplifier code up or down. New codes are issued on a valid/ready stream toward the PGA interface. An optional hold-off lets the RMS window refill before the next decision.

## Interface
- WIDTH, 8: RMS sample width, unsigned.
- GAIN_BITS, 4: gain code width; code 0 = minimum gain, 2^GAIN_BITS-1 = maximum.
- GAIN_RESET, 8: gain code after reset.
- TARGET, 64: desired RMS level.
- HYST, 8: half-width of the dead band around TARGET.
- ATTACK_STEP, 2: codes removed per decision when too loud.
- DECAY_STEP, 1: codes added per decision when too quiet.
- HOLDOFF, 256: settle cycles after an accepted gain change; used only with AGC_HOLDOFF_EN.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rms_TVALID  in  1  RMS sample strobe; no back-pressure exists upstream.
- rms_TDATA  in  WIDTH  RMS sample.
- gain_TVALID  out  1  new gain code offered.
- gain_TDATA  out  GAIN_BITS  offered gain code.
- gain_TREADY  in  1  PGA interface accepts code.
- gain_code  out  GAIN_BITS  currently applied gain.
- at_min, at_max  out  1  gain_code == 0 / == max, combinational from gain_code.
- drop_pulse  out  1  one-cycle pulse when a valid RMS sample is discarded.

## Operation
- States IDLE, EVAL, SEND, HOLD (HOLD only with AGC_HOLDOFF_EN).
- IDLE: on rms_TVALID capture rms_TDATA -> EVAL.
- EVAL (one cycle): hi = min(TARGET+HYST, 2^WIDTH-1), lo = max(TARGET-HYST, 0), computed in WIDTH+1 bits.
  - sample > hi: next = max(gain_code - ATTACK_STEP, 0).
  - sample < lo: next = min(gain_code + DECAY_STEP, max).
  - otherwise, or next == gain_code (already saturated): -> IDLE, no output.
  - else load gain_TDATA = next -> SEND.
- SEND: gain_TVALID high, gain_TDATA stable until gain_TREADY. On handshake gain_code <= gain_TDATA; -> HOLD (macro) or IDLE.
- HOLD: count HOLDOFF cycles, then -> IDLE.
- rms_TVALID in any state other than IDLE: sample discarded, drop_pulse high that cycle.
- Comparisons strict; sample == hi or == lo is in-band.

## Timing
- Reset values: state IDLE, gain_code = GAIN_RESET, gain_TDATA = GAIN_RESET, gain_TVALID 0, drop_pulse 0, hold counter 0.
- rms_TVALID at cycle N -> EVAL at N+1 -> gain_TVALID first high at N+2.
- gain_TREADY already high at N+2: handshake at N+2, gain_code updated at N+3.
- Without hold-off, next sample accepted at N+3 earliest; with it, at N+3+HOLDOFF.
- gain_TVALID never deasserts without a handshake, except on reset.
- Reset mid-SEND or mid-HOLD: gain_TVALID low the following cycle, pending code lost, gain_code back to GAIN_RESET.

## Configuration
- AGC_HOLDOFF_EN defined: HOLD state and counter compiled in; samples during hold-off are dropped.
- Undefined: no counter or HOLD state, SEND returns to IDLE on handshake; HOLDOFF parameter ignored.

## Structure
- agc_pkg: state enum, saturating add/sub function on GAIN_BITS, threshold clamp function.
- Sub-module agc_holdoff_timer (start, done pulse, HOLDOFF parameter), instantiated only under AGC_HOLDOFF_EN.

## Test plan
- Reset, one sample 100 (> 72), TREADY high -> gain_TDATA 6 at N+2, gain_code 6 at N+3.
- Sample 40 (< 56) from gain 8 -> gain_TDATA 9; samples 56, 64, 72 -> no gain_TVALID.
- Gain forced to 0 by repeated 255 samples -> at_min high, further loud samples produce no transaction; at 15 quiet samples leave gain_code 15, at_max high.
- gain_TREADY held low 20 cycles -> gain_TVALID and gain_TDATA stable all 20 cycles; samples arriving meanwhile raise drop_pulse each cycle, gain_code unchanged.
- With AGC_HOLDOFF_EN: sample every cycle after a change -> exactly HOLDOFF drop_pulse-eligible cycles in HOLD before the next capture; without it -> next capture the cycle after handshake.
- Reset asserted while gain_TVALID high -> gain_TVALID 0 next cycle, gain_code 8.
